sequential_shift_add_multiplier: RTL and testbench



---
 rtl/mult_div_pkg.sv | 19 +
 rtl/mult_add_sub.sv | 18 +
 rtl/sequential_shift_add_multiplier.sv | 120 ++++++++++++
 tb/tb_sequential_shift_add_multiplier.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiplier/divider datapath: state encoding,
// default operand width and the iteration-counter width helper.
package mult_div_pkg;

  localparam int unsigned DefaultWidth = 128;

  // One-hot-ish encoding: done is bit 2, busy is bit 0 | bit 1.
  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StAccum = 3'b001,
    StShift = 3'b010,
    StDone  = 3'b100
  } mult_state_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_add_sub.sv
// (WIDTH+1)-bit adder/subtractor: i_add_sub=0 adds, i_add_sub=1 computes i_a - i_b.
module mult_add_sub #(
  parameter int unsigned WIDTH = 128
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  input  logic           i_add_sub,
  output logic [WIDTH:0] o_sum,
  output logic           o_carry_out
);

  logic [WIDTH:0] w_b;

  // Subtraction as a + ~b + 1.
  assign w_b = i_add_sub ? ~i_b : i_b;
  assign {o_carry_out, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{(WIDTH + 1){1'b0}}, i_add_sub};

endmodule

// File: rtl/sequential_shift_add_multiplier.sv
// Iterative shift-add multiplier, one ACCUM/SHIFT pair per multiplier bit (2*WIDTH cycles).
// Define SIGNED_MULT_EN for two's-complement operands; unsigned otherwise.
module sequential_shift_add_multiplier
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand_m,
  input  logic [WIDTH-1:0]   multiplier_q,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_out,
  output logic [CNT_W-1:0]   count_out
);

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH - 1);

  mult_state_e      r_state, w_state_d;
  logic [WIDTH:0]   r_a, w_a_d;
  logic [WIDTH-1:0] r_q, w_q_d;
  logic [WIDTH-1:0] r_m, w_m_d;
  logic [CNT_W-1:0] r_count, w_count_d;

  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_sum;
  logic             w_sub;
  logic             w_carry;
  logic             w_fill;
  logic             w_last;

  assign w_last = (r_count == LastCount);

`ifdef SIGNED_MULT_EN
  // Last multiplier bit carries negative weight in two's complement.
  assign w_m_ext = {r_m[WIDTH-1], r_m};
  assign w_sub   = w_last;
  assign w_fill  = r_a[WIDTH];
`else
  assign w_m_ext = {1'b0, r_m};
  assign w_sub   = 1'b0;
  assign w_fill  = 1'b0;

  // A stays below 2^WIDTH before each add, so the wide add can never carry out.
  always_comb begin
    if (r_state == StAccum && r_q[0]) begin
      assert (!w_carry);
    end
  end
`endif

  mult_add_sub #(
    .WIDTH(WIDTH)
  ) u_add_sub (
    .i_a        (r_a),
    .i_b        (w_m_ext),
    .i_add_sub  (w_sub),
    .o_sum      (w_sum),
    .o_carry_out(w_carry)
  );

  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_q_d     = r_q;
    w_m_d     = r_m;
    w_count_d = r_count;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_m_d     = multiplicand_m;
          w_q_d     = multiplier_q;
          w_a_d     = '0;
          w_count_d = '0;
          w_state_d = StAccum;
        end
      end
      StAccum: begin
        if (r_q[0]) begin
          w_a_d = w_sum;
        end
        w_state_d = StShift;
      end
      StShift: begin
        w_a_d     = {w_fill, r_a[WIDTH:1]};
        w_q_d     = {r_a[0], r_q[WIDTH-1:1]};
        w_count_d = r_count + CNT_W'(1);
        w_state_d = w_last ? StDone : StAccum;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_a     <= w_a_d;
      r_q     <= w_q_d;
      r_m     <= w_m_d;
      r_count <= w_count_d;
    end
  end

  assign product   = {r_a[WIDTH-1:0], r_q};
  assign busy      = r_state[0] | r_state[1];
  assign done      = r_state[2];
  assign state_out = r_state;
  assign count_out = r_count;

endmodule

// File: tb/tb_sequential_shift_add_multiplier.sv
// Directed bench for sequential_shift_add_multiplier with a product scoreboard.
module tb_sequential_shift_add_multiplier;

  localparam int unsigned W = 128;
  localparam int unsigned CW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   m_in;
  logic [W-1:0]   q_in;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;
  logic [2:0]     state_out;
  logic [CW-1:0]  count_out;

  logic [2*W-1:0] sb[$];
  int vectors = 0;
  int miscompares = 0;

  sequential_shift_add_multiplier #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .multiplicand_m(m_in),
    .multiplier_q  (q_in),
    .product       (product),
    .busy          (busy),
    .done          (done),
    .state_out     (state_out),
    .count_out     (count_out)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
`ifdef SIGNED_MULT_EN
    logic signed [2*W-1:0] a;
    logic signed [2*W-1:0] b;
    a = $signed({{W{m[W-1]}}, m});
    b = $signed({{W{q[W-1]}}, q});
    return a * b;
`else
    return {{W{1'b0}}, m} * {{W{1'b0}}, q};
`endif
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive operands with start for one accepting edge and record the expected product.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
    start = 1'b1;
    m_in  = m;
    q_in  = q;
    tick();
    start = 1'b0;
    sb.push_back(model(m, q));
  endtask

  // Wait (bounded) for done; optionally pulse start at the given offsets while busy.
  task automatic wait_done(input string tag, input int pulse_a, input int pulse_b);
    int n;
    int busy_n;
    n      = 0;
    busy_n = 0;
    while (!done && n < 300) begin
      if (busy) busy_n++;
      if (n == pulse_a || n == pulse_b) begin
        start = 1'b1;
        m_in  = {$urandom, $urandom, $urandom, $urandom};
        q_in  = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 256'(n), 256'd256);
    check({tag, "_busy_cycles"}, 256'(busy_n), 256'd256);
    check({tag, "_sb_depth"}, 256'(sb.size()), 256'd1);
    if (sb.size() > 0) check({tag, "_product"}, product, sb.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    m_in  = '0;
    q_in  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_state", 256'(state_out), 256'd0);
    check("rst_count", 256'(count_out), 256'd0);
    check("rst_product", product, 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);

    start_op(128'd7, 128'd6);
    wait_done("7x6", -1, -1);
    check("7x6_const", product, 256'd42);

    start_op(128'd0, '1);
    wait_done("0xones", -1, -1);
    check("0xones_const", product, 256'd0);

    start_op('1, '1);
    wait_done("onesxones", -1, -1);
`ifndef SIGNED_MULT_EN
    check("onesxones_const", product, {{(W-1){1'b1}}, 1'b0, {(W-1){1'b0}}, 1'b1});
`else
    check("onesxones_const", product, 256'd1);
`endif

    // Starts while busy must be ignored without moving the completion edge.
    repeat (5) tick();
    start_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    wait_done("ignore", 40, 90);

    // Abort mid-operation with reset.
    start_op(128'd11, 128'd13);
    repeat (120) tick();
    check("mid_count", 256'(count_out), 256'd60);
    check("mid_busy", 256'(busy), 256'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("abort_state", 256'(state_out), 256'd0);
    check("abort_count", 256'(count_out), 256'd0);
    check("abort_product", product, 256'd0);
    check("abort_done", 256'(done), 256'd0);

    start_op(128'd3, 128'd5);
    wait_done("3x5", -1, -1);
    repeat (5) tick();
    check("hold_product", product, 256'd15);
    check("hold_done", 256'(done), 256'd1);

    // Back-to-back restart from DONE.
    start_op({1'b1, {(W-1){1'b0}}}, 128'd2);
    check("restart_done_low", 256'(done), 256'd0);
    wait_done("b2b", -1, -1);
`ifndef SIGNED_MULT_EN
    check("b2b_const", product, 256'd1 << 128);
`endif

`ifdef SIGNED_MULT_EN
    start_op(-128'sd3, 128'd5);
    wait_done("neg3x5", -1, -1);
    check("neg3x5_const", product, {{(2*W-4){1'b1}}, 4'b0001});

    start_op({1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}});
    wait_done("minxmin", -1, -1);
    check("minxmin_const", product, 256'd1 << 254);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
